// File: rtl/alu_pkg.sv
// Shared opcode, flag and state definitions for alu_seq.
// ALU_SEQ_MUL_EN selects whether the iterative multiplier is built.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_OR  = 4'd3,
    OP_NOT = 4'd4,
    OP_XOR = 4'd5,
    OP_AND = 4'd6,
    OP_SHL = 4'd7,
    OP_SHR = 4'd8,
    OP_SRA = 4'd9
  } alu_op_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } alu_seq_state_e;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = '0;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier: one partial product per clock.
// The final accumulate is presented combinationally with o_done so the
// caller can capture the product on the WIDTH-th step edge.
module alu_seq_mul
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int unsigned    CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic               r_busy;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] w_acc_next;

  // Add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    w_acc_next = r_acc;
    if (r_mplier[0]) begin
      w_acc_next = r_acc + r_mcand;
    end
  end

  assign o_done    = r_busy && (r_cnt == LAST);
  assign o_product = w_acc_next;

  // Operand latch on start, then one shift-add step per clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (i_start) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (o_done) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle ops complete in one clock,
// MUL (only when ALU_SEQ_MUL_EN is defined) iterates over WIDTH clocks.
// Without ALU_SEQ_MUL_EN opcode 2 reports as illegal.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_illegal
);

  localparam int unsigned SHW = $clog2(WIDTH);

  logic [1:0]           r_rst_pipe;
  logic                 w_rst_n;
  alu_seq_state_e       r_state;
  logic                 r_out_valid;
  logic [WIDTH-1:0]     r_result;
  logic [3:0]           r_flags;
  logic                 r_illegal;

  logic                 w_accept;
  logic [SHW-1:0]       w_sh;
  logic [WIDTH:0]       w_add;
  logic [WIDTH:0]       w_sub;
  logic [WIDTH:0]       w_shl;
  logic [WIDTH:0]       w_shr;
  logic signed [WIDTH:0] w_sra_in;
  logic signed [WIDTH:0] w_sra;
  logic [WIDTH-1:0]     w_res;
  logic                 w_c;
  logic                 w_v;
  logic                 w_illegal;
  logic                 w_is_mul;

  // Asynchronous assert, clock-aligned release of the internal reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rst_pipe <= '0;
    end else begin
      r_rst_pipe <= {r_rst_pipe[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_pipe[1];

  assign in_ready    = w_rst_n && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept    = in_valid && in_ready;
  assign out_valid   = r_out_valid;
  assign out_result  = r_result;
  assign out_flags   = r_flags;
  assign out_illegal = r_illegal;

  // Single-cycle datapath; shifts carry one extra bit to expose the last bit out.
  always_comb begin
    w_sh      = in_b[SHW-1:0];
    w_add     = {1'b0, in_a} + {1'b0, in_b};
    w_sub     = {1'b0, in_a} - {1'b0, in_b};
    w_shl     = {1'b0, in_a} << w_sh;
    w_shr     = {in_a, 1'b0} >> w_sh;
    w_sra_in  = {in_a, 1'b0};
    w_sra     = w_sra_in >>> w_sh;
    w_res     = '0;
    w_c       = 1'b0;
    w_v       = 1'b0;
    w_illegal = 1'b0;
    w_is_mul  = 1'b0;
    case (in_op)
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_res[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = ~w_sub[WIDTH];
        w_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_res[WIDTH-1] != in_a[WIDTH-1]);
      end
`ifdef ALU_SEQ_MUL_EN
      OP_MUL: w_is_mul = 1'b1;
`endif
      OP_OR:  w_res = in_a | in_b;
      OP_NOT: w_res = ~in_a;
      OP_XOR: w_res = in_a ^ in_b;
      OP_AND: w_res = in_a & in_b;
      OP_SHL: begin
        w_res = w_shl[WIDTH-1:0];
        w_c   = w_shl[WIDTH];
      end
      OP_SHR: begin
        w_res = w_shr[WIDTH:1];
        w_c   = w_shr[0];
      end
      OP_SRA: begin
        w_res = w_sra[WIDTH:1];
        w_c   = w_sra[0];
      end
      default: w_illegal = 1'b1;
    endcase
  end

`ifdef ALU_SEQ_MUL_EN
  logic                 w_mul_start;
  logic                 w_mul_done;
  logic [2*WIDTH-1:0]   w_product;
  logic                 w_mul_hi;

  assign w_mul_start = w_accept && w_is_mul;
  assign w_mul_hi    = |w_product[2*WIDTH-1:WIDTH];

  alu_seq_mul #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk       (clk),
    .rst_n     (w_rst_n),
    .i_start   (w_mul_start),
    .i_a       (in_a),
    .i_b       (in_b),
    .o_done    (w_mul_done),
    .o_product (w_product)
  );
`endif

  // Control FSM and output register; a stalled result stays untouched.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_illegal   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_is_mul) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_MUL;
          end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_res;
            r_flags     <= pack_flags(w_res[WIDTH-1], w_res == '0, w_c, w_v);
            r_illegal   <= w_illegal;
          end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
`ifdef ALU_SEQ_MUL_EN
        ST_MUL: begin
          if (w_mul_done) begin
            r_out_valid <= 1'b1;
            r_result    <= w_product[WIDTH-1:0];
            r_flags     <= pack_flags(w_product[WIDTH-1], w_product[WIDTH-1:0] == '0,
                                      w_mul_hi, w_mul_hi);
            r_illegal   <= 1'b0;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=32); honours ALU_SEQ_MUL_EN.
module tb_alu_seq;

`ifdef ALU_SEQ_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  typedef struct packed {
    logic        ill;
    logic [3:0]  flags;   // {N,Z,C,V}
    logic [31:0] res;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    exp_t        exp;
    int unsigned lat;
    string       name;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_flags;
  logic        out_illegal;

  int n_checks = 0;
  int n_err    = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_flags   (out_flags),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the opcode rules, using 64-bit integer arithmetic.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t              e;
    longint unsigned   ua;
    longint unsigned   ub;
    longint unsigned   full;
    longint            sa;
    longint            sb;
    longint            s;
    int unsigned       sh;
    logic              c;
    logic              v;
    e    = '0;
    c    = 1'b0;
    v    = 1'b0;
    ua   = {32'd0, a};
    ub   = {32'd0, b};
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sh   = int'(b[4:0]);
    case (op)
      4'd0: begin
        full  = ua + ub;
        e.res = full[31:0];
        c     = full > 64'hFFFF_FFFF;
        s     = sa + sb;
        v     = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd1: begin
        e.res = a - b;
        c     = ua >= ub;
        s     = sa - sb;
        v     = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd2: begin
        if (MUL_EN) begin
          full  = ua * ub;
          e.res = full[31:0];
          c     = (full >> 32) != 0;
          v     = c;
        end else begin
          e.ill = 1'b1;
        end
      end
      4'd3: e.res = a | b;
      4'd4: e.res = ~a;
      4'd5: e.res = a ^ b;
      4'd6: e.res = a & b;
      4'd7: begin
        e.res = a << sh;
        c     = (sh != 0) && (((ua >> (32 - sh)) & 64'd1) != 0);
      end
      4'd8: begin
        e.res = a >> sh;
        c     = (sh != 0) && (((ua >> (sh - 1)) & 64'd1) != 0);
      end
      4'd9: begin
        s     = sa >>> sh;
        e.res = s[31:0];
        c     = (sh != 0) && (((ua >> (sh - 1)) & 64'd1) != 0);
      end
      default: e.ill = 1'b1;
    endcase
    e.flags = {e.res[31], e.res == 32'd0, c, v};
    return e;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned n;
    n        = 0;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) check("send_ready_timeout", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output exp_t got, output int unsigned lat, output bit saw_ready);
    lat       = 1;
    saw_ready = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) saw_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("result_timeout", {63'd0, out_valid}, 64'd1);
    got = {out_illegal, out_flags, out_result};
  endtask

  task automatic wait_ready(input string name);
    int unsigned n;
    n = 0;
    while (!in_ready && n < 6) begin
      @(negedge clk);
      n++;
    end
    check(name, {63'd0, in_ready}, 64'd1);
  endtask

  // Free-running stream with a bench-side queue of expected results.
  task automatic run_stream(input int unsigned n_ops, input bit and_only);
    exp_t        q[$];
    exp_t        e;
    bit          stalled;
    bit          tog;
    int unsigned issued;
    int unsigned cyc;
    stalled = 1'b0;
    tog     = 1'b1;
    issued  = 0;
    cyc     = 0;
    while ((issued < n_ops || q.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (and_only) begin
        out_ready = tog;
        tog       = ~tog;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
      if (issued < n_ops && (and_only || $urandom_range(0, 4) != 0)) begin
        in_valid = 1'b1;
        in_op    = and_only ? 4'd6 : 4'($urandom_range(0, 15));
        in_a     = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
        in_b     = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stalled) check("stall_hold_valid", {63'd0, out_valid}, 64'd1);
      if (out_valid) begin
        if (q.size() == 0) begin
          check("unexpected_output", {63'd0, out_valid}, 64'd0);
        end else begin
          check(and_only ? "and_stream" : "rand_stream",
                {27'd0, out_illegal, out_flags, out_result}, {27'd0, q[0]});
          if (out_ready) e = q.pop_front();
        end
      end
      stalled = out_valid && !out_ready;
      if (in_valid && in_ready) begin
        q.push_back(model(in_op, in_a, in_b));
        issued++;
      end
    end
    if (cyc >= 20000) check("stream_timeout", 64'(cyc), 64'd0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    vec_t        vecs[$];
    exp_t        got;
    int unsigned lat;
    bit          saw;
    bit          seen;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_a      = '0;
    in_b      = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_outputs", {27'd0, out_illegal, out_flags, out_result}, 64'd0);
    reset_n = 1'b1;
    wait_ready("reset_in_ready");
    check("post_reset_out_valid", {63'd0, out_valid}, 64'd0);

    // Directed vectors: expected values worked out by hand
    vecs.push_back('{4'd0, 32'hFFFF_FFFF, 32'h1, '{1'b0, 4'b0110, 32'h0}, 1, "add_wrap"});
    vecs.push_back('{4'd0, 32'h7FFF_FFFF, 32'h1, '{1'b0, 4'b1001, 32'h8000_0000}, 1, "add_ovf"});
    vecs.push_back('{4'd1, 32'h8000_0000, 32'h1, '{1'b0, 4'b0011, 32'h7FFF_FFFF}, 1, "sub_ovf"});
    vecs.push_back('{4'd1, 32'h1, 32'h2, '{1'b0, 4'b1000, 32'hFFFF_FFFF}, 1, "sub_borrow"});
    if (MUL_EN) begin
      vecs.push_back('{4'd2, 32'h0001_0000, 32'h0001_0000, '{1'b0, 4'b0111, 32'h0}, 33, "mul_hi"});
      vecs.push_back('{4'd2, 32'd7, 32'd6, '{1'b0, 4'b0000, 32'd42}, 33, "mul_7x6"});
    end else begin
      vecs.push_back('{4'd2, 32'h0001_0000, 32'h0001_0000, '{1'b1, 4'b0100, 32'h0}, 1, "mul_off"});
      vecs.push_back('{4'd2, 32'd7, 32'd6, '{1'b1, 4'b0100, 32'h0}, 1, "mul_off_7x6"});
    end
    vecs.push_back('{4'd9, 32'h8000_0001, 32'h1, '{1'b0, 4'b1010, 32'hC000_0000}, 1, "sra_1"});
    vecs.push_back('{4'd7, 32'h1234_5678, 32'h0, '{1'b0, 4'b0000, 32'h1234_5678}, 1, "shl_0"});
    vecs.push_back('{4'd7, 32'h8000_0000, 32'h1, '{1'b0, 4'b0110, 32'h0}, 1, "shl_out"});
    vecs.push_back('{4'd7, 32'h1, 32'h21, '{1'b0, 4'b0000, 32'h2}, 1, "shl_amt_mask"});
    vecs.push_back('{4'd8, 32'h3, 32'h1, '{1'b0, 4'b0010, 32'h1}, 1, "shr_1"});
    vecs.push_back('{4'd12, 32'h5, 32'h7, '{1'b1, 4'b0100, 32'h0}, 1, "illegal_12"});
    vecs.push_back('{4'd15, 32'hFFFF_FFFF, 32'h1, '{1'b1, 4'b0100, 32'h0}, 1, "illegal_15"});
    vecs.push_back('{4'd3, 32'hF0F0_0000, 32'h0F0F_0000, '{1'b0, 4'b1000, 32'hFFFF_0000}, 1, "or"});
    vecs.push_back('{4'd4, 32'hFFFF_FFFF, 32'h5, '{1'b0, 4'b0100, 32'h0}, 1, "not"});
    vecs.push_back('{4'd5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, '{1'b0, 4'b0100, 32'h0}, 1, "xor"});
    vecs.push_back('{4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, '{1'b0, 4'b1000, 32'hF000_F000}, 1, "and"});

    out_ready = 1'b1;
    @(negedge clk);
    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_result(got, lat, saw);
      check({vecs[i].name, "_value"}, {27'd0, got}, {27'd0, vecs[i].exp});
      check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].lat));
      if (lat > 1) check({vecs[i].name, "_in_ready_low"}, {63'd0, saw}, 64'd0);
    end

    // Back-to-back ANDs with out_ready toggling, then randomized mix
    run_stream(10, 1'b1);
    run_stream(300, 1'b0);

    // Reset while a result is held by a stalled consumer
    @(negedge clk);
    out_ready = 1'b0;
    send(4'd0, 32'd1, 32'd1);
    check("held_before_reset", {27'd0, out_illegal, out_flags, out_result, 1'b0, out_valid},
          {27'd0, 1'b0, 4'b0000, 32'd2, 1'b0, 1'b1});
    reset_n = 1'b0;
    #1;
    check("held_reset_valid", {63'd0, out_valid}, 64'd0);
    check("held_reset_outputs", {27'd0, out_illegal, out_flags, out_result}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready("held_release_ready");

    // Reset at cycle 10 of a MUL; nothing may emerge afterwards
    out_ready = 1'b1;
    @(negedge clk);
    send(4'd2, 32'd7, 32'd6);
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mul_reset_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    wait_ready("mul_release_ready");
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mul_reset_discard", {63'd0, seen}, 64'd0);
    send(4'd0, 32'd2, 32'd3);
    wait_result(got, lat, saw);
    check("post_reset_add", {27'd0, got}, {27'd0, 1'b0, 4'b0000, 32'd5});
    check("post_reset_add_latency", 64'(lat), 64'd1);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, handshaked successor to the combinational ALU: accepts one operation per transaction on a valid/ready input channel and returns a registered result with status flags on a valid/ready output channel. Single-cycle ops complete in one clock; MUL runs as an iterative shift-add over WIDTH cycles, so it needs no wide array multiplier. Sits between decode/operand fetch and writeback in the core datapath.

## Interface
- WIDTH, 32, operand/result width; legal range 2..64, power of two.
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  block accepts operation this cycle.
- in_op  in  4  opcode (alu_pkg::alu_op_e).
- in_a  in  WIDTH  operand 0.
- in_b  in  WIDTH  operand 1 (shift amount = in_b[$clog2(WIDTH)-1:0]).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  WIDTH  result.
- out_flags  out  4  {N, Z, C, V}.
- out_illegal  out  1  opcode was illegal or compiled out.

## Operation
- Opcodes: ADD=0, SUB=1, MUL=2, OR=3, NOT=4, XOR=5, AND=6, SHL=7, SHR=8, SRA=9; 10..15 illegal.
- FSM states IDLE, MUL, HOLD. IDLE: in_ready = !out_valid || out_ready. Accept = in_valid && in_ready.
- Accept non-MUL in IDLE: result/flags registered, out_valid=1 next cycle, stay IDLE (back-to-back at 1 op/cycle when out_ready=1).
- Accept MUL in IDLE: latch operands, go MUL, in_ready=0. Iteration counter counts WIDTH steps, then load result, out_valid=1, go HOLD. HOLD: in_ready=0 until out_ready; on handshake go IDLE.
- Output register holds result/flags stable while out_valid && !out_ready.
- Arithmetic: results truncated to WIDTH. N = result[WIDTH-1]; Z = (result==0).
- ADD: C = carry out, V = signed overflow. SUB: a-b, C = 1 when a>=b unsigned (no borrow), V = signed overflow.
- MUL: unsigned, low WIDTH bits; C = V = (upper WIDTH bits of full product != 0).
- OR/NOT/XOR/AND: C=V=0; NOT ignores in_b.
- SHL/SHR/SRA: C = last bit shifted out, 0 for shift amount 0; V=0.
- Illegal: result 0, flags {0,1,0,0}, out_illegal=1; same 1-cycle latency as logic ops.

## Timing
- Reset (async assert, sync-clean deassert inside block): state IDLE, out_valid=0, out_result=0, out_flags=0, out_illegal=0, counter=0; in_ready=1 from first cycle after reset.
- Latency accept->out_valid: 1 cycle non-MUL; WIDTH+1 cycles MUL.
- Reset mid-MUL or with out_valid held: operation/result discarded, no output.
- Simultaneous out handshake and new accept in IDLE: new result replaces old in same edge, out_valid stays 1.
- in_* ignored whenever in_ready=0.

## Configuration
- ALU_SEQ_MUL_EN defined: MUL state, counter and alu_seq_mul present; MUL behaves as above.
- Not defined: no MUL state or multiplier logic; opcode 2 treated as illegal (1-cycle, out_illegal=1). Ports unchanged.

## Structure
- alu_pkg: alu_op_e enum (4-bit, values above), flag index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0), alu_seq_state_e.
- Sub-module alu_seq_mul: iterative shift-add multiplier, start/done, 2*WIDTH product, parameter WIDTH.
- Single-cycle datapath and FSM stay in alu_seq.

## Test plan
- ADD 0xFFFFFFFF + 1, out_ready=1 -> 1 cycle later result 0x00000000, flags N0 Z1 C1 V0.
- SUB 0x80000000 - 1 -> result 0x7FFFFFFF, N0 Z0 C1 V1; SUB 1 - 2 -> 0xFFFFFFFF, N1 C0 V0.
- MUL 0x00010000 * 0x00010000 -> after 33 cycles result 0, Z1 C1 V1; in_ready=0 throughout; MUL 7*6 -> 42, C0.
- Back-to-back 10 ANDs with out_ready toggling 1/0 -> no loss/duplication, result stable while stalled, in order.
- SRA 0x80000001 by 1 -> 0xC0000000, C1; SHL x by 0 -> x, C0; opcode 12 -> result 0, out_illegal=1, Z1.
- reset_n low at cycle 10 of MUL -> out_valid=0 immediately, in_ready=1 after release, next ADD 2+3 -> 5.
